// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART RX frame checker.
//   state_e     : frame FSM states (IDLE=0 .. DONE=4)
//   PARITY_EVEN : par_typ value selecting even parity
//   PARITY_ODD  : par_typ value selecting odd parity
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_frame_check_sat_counter.sv
// Saturating event counter used for the UART RX error statistics.
//   clk     : system clock
//   reset_n : synchronous active-low reset, clears the count
//   inc     : add one (held at all-ones once reached)
//   clr     : synchronous clear, has priority over inc
//   cnt     : current count
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker. Consumes one validated sample per bit period and
// tracks start, DATA_WIDTH data bits (LSB first), optional parity and one or
// two stop bits; reports parity/stop/break conditions and keeps saturating
// error counters.
//   clk, reset_n        : clock, synchronous active-low reset
//   rx_en               : enable; low aborts any frame in progress
//   sampled_bit         : majority-voted RX bit, qualified by sample_valid
//   par_en/par_typ      : parity present / odd parity (latched at start bit)
//   stop_2              : two stop bits (latched at start bit)
//   clr_cnt             : clear both error counters
//   data_out            : received data, updated with frame_done
//   frame_done          : 1-cycle pulse when a frame completes
//   data_valid          : frame_done without parity or stop error
//   par_err/stp_err/break_det : flags of the last frame, held until next frame_done
//   busy                : FSM not idle
//   par_err_cnt/stp_err_cnt   : saturating error counters
module uart_rx_frame_check
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_en,
  input  logic                  sampled_bit,
  input  logic                  sample_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop_2,
  input  logic                  clr_cnt,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  break_det,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

  localparam int unsigned BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  state_e                state_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_en_q, par_typ_q, stop2_q;
  logic                  stop_cnt_q;
  logic                  par_bad_q, stp_bad_q;
  // Any 1 seen in the parity or stop samples; together with all-zero data
  // this decides the break condition.
  logic                  seen_one_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  frame_done_q, data_valid_q;
  logic                  par_err_q, stp_err_q, break_q;

  logic par_exp, stp_now, brk_now;

  assign par_exp = (^shift_q) ^ (par_typ_q == PARITY_ODD);
  // Values for the final stop sample, folded in when moving to DONE.
  assign stp_now = stp_bad_q | ~sampled_bit;
  assign brk_now = (shift_q == '0) & ~seen_one_q & ~sampled_bit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      stop2_q      <= 1'b0;
      stop_cnt_q   <= 1'b0;
      par_bad_q    <= 1'b0;
      stp_bad_q    <= 1'b0;
      seen_one_q   <= 1'b0;
      data_out_q   <= '0;
      frame_done_q <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      break_q      <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      data_valid_q <= 1'b0;
      if (!rx_en) begin
        state_q   <= IDLE;
        bit_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (sample_valid && !sampled_bit) begin
              state_q    <= DATA;
              par_en_q   <= par_en;
              par_typ_q  <= par_typ;
              stop2_q    <= stop_2;
              bit_cnt_q  <= '0;
              stop_cnt_q <= 1'b0;
              par_bad_q  <= 1'b0;
              stp_bad_q  <= 1'b0;
              seen_one_q <= 1'b0;
            end
          end
          DATA: begin
            if (sample_valid) begin
              shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
              if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_q <= '0;
                state_q   <= par_en_q ? PARITY : STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end
          PARITY: begin
            if (sample_valid) begin
              par_bad_q <= (sampled_bit != par_exp);
              if (sampled_bit) seen_one_q <= 1'b1;
              state_q <= STOP;
            end
          end
          STOP: begin
            if (sample_valid) begin
              if (stop2_q && !stop_cnt_q) begin
                stop_cnt_q <= 1'b1;
                stp_bad_q  <= stp_now;
                if (sampled_bit) seen_one_q <= 1'b1;
              end else begin
                // Outputs are registered here so they are visible during DONE.
                state_q      <= DONE;
                frame_done_q <= 1'b1;
                data_out_q   <= shift_q;
                par_err_q    <= par_bad_q;
                stp_err_q    <= stp_now;
                break_q      <= brk_now;
                data_valid_q <= ~par_bad_q & ~stp_now;
              end
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_par_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (frame_done_q & par_err_q),
    .clr     (clr_cnt),
    .cnt     (par_err_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stp_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (frame_done_q & stp_err_q),
    .clr     (clr_cnt),
    .cnt     (stp_err_cnt)
  );

  assign data_out   = data_out_q;
  assign frame_done = frame_done_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;
  assign break_det  = break_q;
  assign busy       = (state_q != IDLE);

endmodule
